// File: rtl/conv_window_feeder.sv
// conv_window_feeder
//   Upstream stage of the 3x3 convolution core. It takes a serial byte stream on in_data:
//   first 9 weights, then IMG_W*IMG_H pixels, both row-major. It then issues one 3x3 window
//   at a time, with a single-cycle win_valid pulse for each. The next window is issued only
//   after the core returns ofm_valid for the current one.
//
//   Parameters: IMG_W, IMG_H (3..255) -- image size in pixels.
//   Build option: CONV_ZERO_PAD_EN -- the window index is the centre pixel, every pixel gets
//     a window, and taps that fall outside the image read as zero. When the macro is not
//     defined, only full windows are issued and the index is the top-left pixel.
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid/in_data    input byte stream (accepted while in_ready=1)
//     in_ready            high while idle or loading
//     ofm_valid           result strobe from the core; only acted on in WAIT
//     win_valid           one-cycle pulse marking a new window on win_*
//     win_ifm/win_wgt     window pixels / kernel; bits [8k+7:8k] = element k+1 (row-major)
//     win_row/win_col     index of the window currently presented
//     busy                high in ISSUE/WAIT
//     done                one-cycle pulse after the final window's ofm_valid
module conv_window_feeder #(
  parameter int IMG_W = 5,
  parameter int IMG_H = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        ofm_valid,
  output logic        win_valid,
  output logic [71:0] win_ifm,
  output logic [71:0] win_wgt,
  output logic [7:0]  win_row,
  output logic [7:0]  win_col,
  output logic        busy,
  output logic        done
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = $clog2(NPIX);
`ifdef CONV_ZERO_PAD_EN
  localparam int ROW_LAST = IMG_H - 1;
  localparam int COL_LAST = IMG_W - 1;
`else
  localparam int ROW_LAST = IMG_H - 3;
  localparam int COL_LAST = IMG_W - 3;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_LOAD_P, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [AW-1:0]   pcnt_q, pcnt_d;
  logic [7:0]      row_q, row_d, col_q, col_d;
  logic [7:0]      wgt_q [9];
  logic [7:0]      wgt_d [9];
  logic [7:0]      pix_q [NPIX];
  logic [7:0]      pix_d [NPIX];
  logic            win_valid_q, win_valid_d;
  logic [71:0]     win_ifm_q, win_ifm_d, win_wgt_q, win_wgt_d;
  logic [7:0]      win_row_q, win_row_d, win_col_q, win_col_d;
  logic            done_q, done_d;

  logic            accept, last_pix, last_win;
  logic [71:0]     taps;

  assign accept   = in_valid && in_ready;
  assign last_pix = (pcnt_q == AW'(NPIX - 1));
  assign last_win = (row_q == 8'(ROW_LAST)) && (col_q == 8'(COL_LAST));

  // State register and all datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      pcnt_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      wgt_q       <= '{default: '0};
      pix_q       <= '{default: '0};
      win_valid_q <= 1'b0;
      win_ifm_q   <= '0;
      win_wgt_q   <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      pcnt_q      <= pcnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      wgt_q       <= wgt_d;
      pix_q       <= pix_d;
      win_valid_q <= win_valid_d;
      win_ifm_q   <= win_ifm_d;
      win_wgt_q   <= win_wgt_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      done_q      <= done_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_LOAD_W;
      S_LOAD_W: if (accept && wcnt_q == 4'd8) state_d = S_LOAD_P;
      S_LOAD_P: if (accept && last_pix) state_d = S_ISSUE;
      S_ISSUE:  state_d = S_WAIT;
      S_WAIT:   if (ofm_valid) state_d = last_win ? S_DONE : S_ISSUE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready = (state_q == S_IDLE) || (state_q == S_LOAD_W) || (state_q == S_LOAD_P);
    busy     = (state_q == S_ISSUE) || (state_q == S_WAIT);
  end

  // Tap gather for the window at (row_q, col_q)
  always_comb begin : tap_sel
`ifdef CONV_ZERO_PAD_EN
    int r;
    int c;
    r = 0;
    c = 0;
`endif
    taps = '0;
    for (int unsigned dr = 0; dr < 3; dr++) begin
      for (int unsigned dc = 0; dc < 3; dc++) begin
`ifdef CONV_ZERO_PAD_EN
        r = int'(row_q) + int'(dr) - 1;
        c = int'(col_q) + int'(dc) - 1;
        if (r >= 0 && r < IMG_H && c >= 0 && c < IMG_W)
          taps[8*(3*dr+dc) +: 8] = pix_q[AW'(r * IMG_W + c)];
`else
        taps[8*(3*dr+dc) +: 8] =
          pix_q[AW'((int'(row_q) + int'(dr)) * IMG_W + int'(col_q) + int'(dc))];
`endif
      end
    end
  end

  // Datapath next values
  always_comb begin
    wcnt_d      = wcnt_q;
    pcnt_d      = pcnt_q;
    row_d       = row_q;
    col_d       = col_q;
    wgt_d       = wgt_q;
    pix_d       = pix_q;
    win_valid_d = 1'b0;
    win_ifm_d   = win_ifm_q;
    win_wgt_d   = win_wgt_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    done_d      = (state_q == S_DONE);

    if (accept) begin
      if (state_q == S_IDLE) begin
        wgt_d[0] = in_data;
        wcnt_d   = 4'd1;
        pcnt_d   = '0;
        row_d    = '0;
        col_d    = '0;
      end else if (state_q == S_LOAD_W) begin
        wgt_d[wcnt_q] = in_data;
        wcnt_d        = wcnt_q + 4'd1;
      end else begin
        pix_d[pcnt_q] = in_data;
        pcnt_d        = pcnt_q + 1'b1;
      end
    end

    // Window outputs are captured only here, so they hold through WAIT and beyond
    if (state_q == S_ISSUE) begin
      win_valid_d = 1'b1;
      win_ifm_d   = taps;
      for (int unsigned k = 0; k < 9; k++)
        win_wgt_d[8*k +: 8] = wgt_q[4'(k)];
      win_row_d   = row_q;
      win_col_d   = col_q;
    end

    if (state_q == S_WAIT && ofm_valid) begin
      if (last_win) begin
        row_d = '0;
        col_d = '0;
      end else if (col_q == 8'(COL_LAST)) begin
        col_d = '0;
        row_d = row_q + 8'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
    end
  end

  assign win_valid = win_valid_q;
  assign win_ifm   = win_ifm_q;
  assign win_wgt   = win_wgt_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign done      = done_q;

endmodule
